vga_ctrl: RTL and testbench



---
 rtl/vga_ctrl_if.sv | 24 ++
 rtl/vga_ctrl.sv | 147 ++++++++++++++
 tb/tb_vga_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_ctrl_if.sv
// Framebuffer read port plus board-side VGA pins for the scan-out engine.
// master: the scan-out engine (vga_ctrl); slave: framebuffer and pin side.
interface vga_ctrl_if;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic [11:0] vga_data;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        hsync;
  logic        vsync;
  logic        valid;
  logic        frame_start;

  modport master (
    output h_addr, v_addr, vga_r, vga_g, vga_b, hsync, vsync, valid, frame_start,
    input  vga_data
  );

  modport slave (
    input  h_addr, v_addr, vga_r, vga_g, vga_b, hsync, vsync, valid, frame_start,
    output vga_data
  );
endinterface

// File: rtl/vga_ctrl.sv
// VGA scan-out engine. Divides the system clock down to a pixel tick, walks
// the raster with h/v counters, presents the active pixel address to the
// framebuffer and registers the returned pixel onto the pins. hsync, vsync
// and the active flag are delayed by FB_LATENCY ticks so they line up with
// the pixel data coming back from the framebuffer.
module vga_ctrl #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FB_LATENCY = 0,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33
) (
  input  logic       clock,
  input  logic       reset,
  vga_ctrl_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0] div;
  logic       tick;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       v_wrap;
  logic       act;
  logic       hs_n;
  logic       vs_n;
  logic       act_d;
  logic       hs_d;
  logic       vs_d;

  // Pixel-tick divider; first tick lands on the CLK_DIV-th clock after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 4'd1;
    end
  end

  // Raw raster decode straight from the counters; addresses are forced to 0
  // outside the visible window so the framebuffer never sees out-of-range
  // coordinates.
  always_comb begin
    tick       = (div == DIV_MAX);
    h_wrap     = (h_cnt == H_MAX);
    v_wrap     = (v_cnt == V_MAX);
    act        = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_n       = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    vs_n       = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    vga.h_addr = act ? h_cnt : 10'd0;
    vga.v_addr = act ? v_cnt : 10'd0;
  end

  // Raster position counters, advanced once per pixel tick.
  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  generate
    if (FB_LATENCY == 0) begin : g_no_lat
      assign act_d = act;
      assign hs_d  = hs_n;
      assign vs_d  = vs_n;
    end else begin : g_lat
      logic [FB_LATENCY-1:0] act_sr;
      logic [FB_LATENCY-1:0] hs_sr;
      logic [FB_LATENCY-1:0] vs_sr;

      // Delay line matching the framebuffer read latency; resets to blanking.
      always_ff @(posedge clock) begin
        if (reset) begin
          act_sr <= '0;
          hs_sr  <= '1;
          vs_sr  <= '1;
        end else if (tick) begin
          act_sr[0] <= act;
          hs_sr[0]  <= hs_n;
          vs_sr[0]  <= vs_n;
          for (int i = 1; i < FB_LATENCY; i++) begin
            act_sr[i] <= act_sr[i-1];
            hs_sr[i]  <= hs_sr[i-1];
            vs_sr[i]  <= vs_sr[i-1];
          end
        end
      end

      assign act_d = act_sr[FB_LATENCY-1];
      assign hs_d  = hs_sr[FB_LATENCY-1];
      assign vs_d  = vs_sr[FB_LATENCY-1];
    end
  endgenerate

  // Pin register: loads on tick, holds between ticks, RGB blanked when inactive.
  always_ff @(posedge clock) begin
    if (reset) begin
      {vga.vga_r, vga.vga_g, vga.vga_b} <= 12'h000;
      vga.hsync <= 1'b1;
      vga.vsync <= 1'b1;
      vga.valid <= 1'b0;
    end else if (tick) begin
      {vga.vga_r, vga.vga_g, vga.vga_b} <= act_d ? vga.vga_data : 12'h000;
      vga.hsync <= hs_d;
      vga.vsync <= vs_d;
      vga.valid <= act_d;
    end
  end

  // One-clock frame marker on the wrap to (0,0); deliberately not pipelined.
  always_ff @(posedge clock) begin
    if (reset) begin
      vga.frame_start <= 1'b0;
    end else begin
      vga.frame_start <= tick && h_wrap && v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl using a shrunken raster so whole frames fit in a short
// run. dut0: CLK_DIV=4, no framebuffer latency, combinational data source.
// dut2: CLK_DIV=1, FB_LATENCY=2, fed by a two-stage framebuffer model.
module tb_vga_ctrl;

  localparam int HA = 40, HFP = 4, HS = 8, HBP = 6;
  localparam int VA = 20, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        valid;
  } pins_t;

  localparam pins_t RESET_PINS = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, valid: 1'b0};

  logic clock = 1'b0;
  logic rst0  = 1'b1;
  logic rst2  = 1'b1;
  logic use_abc = 1'b0;
  logic [11:0] fb_d1 = 12'hABC;
  logic [11:0] fb_d2 = 12'hABC;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  vga_ctrl_if bus0 ();
  vga_ctrl_if bus2 ();

  vga_ctrl #(
    .CLK_DIV(4), .FB_LATENCY(0),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut0 (.clock(clock), .reset(rst0), .vga(bus0));

  vga_ctrl #(
    .CLK_DIV(1), .FB_LATENCY(2),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut2 (.clock(clock), .reset(rst2), .vga(bus2));

  function automatic logic [11:0] pat(input logic [9:0] a);
    return {a[3:0], a[3:0], a[3:0]};
  endfunction

  assign bus0.vga_data = use_abc ? 12'hABC : pat(bus0.h_addr);

  // Two-tick framebuffer (tick == clock for dut2).
  always @(posedge clock) begin
    fb_d1 <= pat(bus2.h_addr);
    fb_d2 <= fb_d1;
  end
  assign bus2.vga_data = fb_d2;

  // Expected pins for raster state t (ticks since reset).
  function automatic pins_t model_pins(input int t, input bit abc);
    int h, v;
    bit a;
    pins_t r;
    h = t % HT;
    v = (t / HT) % VT;
    a = (h < HA) && (v < VA);
    r.rgb   = a ? (abc ? 12'hABC : pat(10'(h))) : 12'h000;
    r.hs    = !((h >= HA + HFP) && (h < HA + HFP + HS));
    r.vs    = !((v >= VA + VFP) && (v < VA + VFP + VS));
    r.valid = a;
    return r;
  endfunction

  function automatic logic [19:0] model_addr(input int t);
    int h, v;
    h = t % HT;
    v = (t / HT) % VT;
    if ((h < HA) && (v < VA)) return {10'(h), 10'(v)};
    return 20'd0;
  endfunction

  task automatic test_reset();
    pins_t cur;
    logic [9:0] exp_h;
    @(negedge clock);
    rst0 = 1'b1;
    repeat (3) @(negedge clock);
    cur = {bus0.vga_r, bus0.vga_g, bus0.vga_b, bus0.hsync, bus0.vsync, bus0.valid};
    checks++;
    if ({cur, bus0.frame_start} !== {RESET_PINS, 1'b0}) begin
      errors++;
      $display("FAIL reset_pins got=%h exp=%h", {cur, bus0.frame_start}, {RESET_PINS, 1'b0});
    end
    checks++;
    if ({bus0.h_addr, bus0.v_addr} !== 20'd0) begin
      errors++;
      $display("FAIL reset_addr got=%h exp=0", {bus0.h_addr, bus0.v_addr});
    end
    rst0 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      exp_h = (i == 4) ? 10'd1 : 10'd0;
      checks++;
      if (bus0.valid !== (i == 4)) begin
        errors++;
        $display("FAIL first_tick_valid clk=%0d got=%b exp=%b", i, bus0.valid, (i == 4));
      end
      checks++;
      if (bus0.h_addr !== exp_h) begin
        errors++;
        $display("FAIL first_tick_haddr clk=%0d got=%0d exp=%0d", i, bus0.h_addr, exp_h);
      end
    end
  endtask

  task automatic test_frame();
    pins_t q[$];
    pins_t held, cur;
    int t, fs_prev, fs_gap, hs_falls, valid_ticks;
    logic exp_fs, hs_last;
    fs_prev = -1; fs_gap = -1; hs_falls = 0; valid_ticks = 0; hs_last = 1'b1;
    use_abc = 1'b0;
    @(negedge clock); rst0 = 1'b1;
    @(negedge clock); rst0 = 1'b0;
    held = RESET_PINS;
    for (int n = 1; n <= 2 * FT * 4 + 8; n++) begin
      @(negedge clock);
      exp_fs = 1'b0;
      if (n % 4 == 0) begin
        t = n / 4 - 1;
        q.push_back(model_pins(t, 1'b0));
        held = q.pop_front();
        exp_fs = ((t % FT) == FT - 1);
      end
      cur = {bus0.vga_r, bus0.vga_g, bus0.vga_b, bus0.hsync, bus0.vsync, bus0.valid};
      checks++;
      if (cur !== held) begin
        errors++;
        $display("FAIL frame_pins clk=%0d got=%h exp=%h", n, cur, held);
      end
      checks++;
      if (bus0.frame_start !== exp_fs) begin
        errors++;
        $display("FAIL frame_start clk=%0d got=%b exp=%b", n, bus0.frame_start, exp_fs);
      end
      checks++;
      if ({bus0.h_addr, bus0.v_addr} !== model_addr(n / 4)) begin
        errors++;
        $display("FAIL frame_addr clk=%0d got=%h exp=%h", n, {bus0.h_addr, bus0.v_addr}, model_addr(n / 4));
      end
      if (fs_prev >= 0 && fs_gap < 0) begin
        if (hs_last && !bus0.hsync) hs_falls++;
        if (n % 4 == 0 && bus0.valid) valid_ticks++;
      end
      if (bus0.frame_start) begin
        if (fs_prev >= 0 && fs_gap < 0) fs_gap = n - fs_prev;
        fs_prev = n;
      end
      hs_last = bus0.hsync;
    end
    checks++;
    if (fs_gap != FT * 4) begin
      errors++;
      $display("FAIL frame_period got=%0d exp=%0d", fs_gap, FT * 4);
    end
    checks++;
    if (hs_falls != VT) begin
      errors++;
      $display("FAIL hsync_pulses got=%0d exp=%0d", hs_falls, VT);
    end
    checks++;
    if (valid_ticks != HA * VA) begin
      errors++;
      $display("FAIL valid_ticks got=%0d exp=%0d", valid_ticks, HA * VA);
    end
  endtask

  task automatic test_blanking();
    pins_t q[$];
    pins_t e, cur;
    use_abc = 1'b1;
    @(negedge clock); rst0 = 1'b1;
    @(negedge clock); rst0 = 1'b0;
    for (int n = 1; n <= FT * 4 + 4; n++) begin
      @(negedge clock);
      if (n % 4 == 0) begin
        q.push_back(model_pins(n / 4 - 1, 1'b1));
        e = q.pop_front();
        cur = {bus0.vga_r, bus0.vga_g, bus0.vga_b, bus0.hsync, bus0.vsync, bus0.valid};
        checks++;
        if (cur !== e) begin
          errors++;
          $display("FAIL blank_pins tick=%0d got=%h exp=%h", n / 4 - 1, cur, e);
        end
        checks++;
        if ({bus0.h_addr, bus0.v_addr} !== model_addr(n / 4)) begin
          errors++;
          $display("FAIL blank_addr tick=%0d got=%h exp=%h", n / 4, {bus0.h_addr, bus0.v_addr}, model_addr(n / 4));
        end
      end
    end
    use_abc = 1'b0;
  endtask

  task automatic test_latency2();
    pins_t q[$];
    pins_t e, cur;
    logic exp_fs;
    @(negedge clock); rst2 = 1'b1;
    @(negedge clock); rst2 = 1'b0;
    for (int n = 1; n <= FT + 6; n++) begin
      @(negedge clock);
      q.push_back(model_pins(n - 1, 1'b0));
      if (q.size() > 2) e = q.pop_front();
      else e = RESET_PINS;
      cur = {bus2.vga_r, bus2.vga_g, bus2.vga_b, bus2.hsync, bus2.vsync, bus2.valid};
      checks++;
      if (cur !== e) begin
        errors++;
        $display("FAIL lat2_pins clk=%0d got=%h exp=%h", n, cur, e);
      end
      exp_fs = (((n - 1) % FT) == FT - 1);
      checks++;
      if (bus2.frame_start !== exp_fs) begin
        errors++;
        $display("FAIL lat2_frame_start clk=%0d got=%b exp=%b", n, bus2.frame_start, exp_fs);
      end
    end
  endtask

  task automatic test_mid_reset();
    pins_t cur;
    int first;
    use_abc = 1'b0;
    @(negedge clock); rst0 = 1'b1;
    @(negedge clock); rst0 = 1'b0;
    repeat (4 * (10 * HT + 20)) @(negedge clock);
    checks++;
    if ({bus0.h_addr, bus0.v_addr} !== {10'd20, 10'd10}) begin
      errors++;
      $display("FAIL mid_pos got=%0d,%0d exp=20,10", bus0.h_addr, bus0.v_addr);
    end
    rst0 = 1'b1;
    @(negedge clock);
    rst0 = 1'b0;
    cur = {bus0.vga_r, bus0.vga_g, bus0.vga_b, bus0.hsync, bus0.vsync, bus0.valid};
    checks++;
    if ({cur, bus0.frame_start} !== {RESET_PINS, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_pins got=%h exp=%h", {cur, bus0.frame_start}, {RESET_PINS, 1'b0});
    end
    checks++;
    if ({bus0.h_addr, bus0.v_addr} !== 20'd0) begin
      errors++;
      $display("FAIL mid_reset_addr got=%h exp=0", {bus0.h_addr, bus0.v_addr});
    end
    first = -1;
    for (int n = 1; n <= FT * 4 + 16; n++) begin
      @(negedge clock);
      if (bus0.frame_start) begin
        first = n;
        break;
      end
    end
    checks++;
    if (first != FT * 4) begin
      errors++;
      $display("FAIL mid_reset_next_frame got=%0d exp=%0d", first, FT * 4);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_blanking();
    test_latency2();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
